alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Issue-side driver for the 64-bit combinational ALU.
- Accepts decoded RISC-V R-type, I-type ALU and branch requests over a valid/ready handshake, and encodes funct3/funct7 into the 4-bit ALU control code.
- Registers operands and control onto the ALU input ports (stage E), then captures the ALU result and zero flag into an output stage (stage W) with backpressure.
- Resolves branch outcome from z_flag, flags illegal encodings and counts them.

Parameters:
XLEN, 64, operand/result width
CNT_W, 16, width of illegal-op counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready at rising edge
in_op  input  2  00 R-type, 01 I-type ALU, 10 branch, 11 reserved (illegal)
in_funct3  input  3  instruction funct3
in_funct7b5  input  1  instruction bit 30
in_rs1  input  XLEN  source operand 1
in_rs2  input  XLEN  source operand 2
in_imm  input  XLEN  sign-extended immediate (used by I-type only)
in_rd  input  5  destination register
alu_a  output  XLEN  ALU operand a (registered)
alu_b  output  XLEN  ALU operand b (registered)
alu_control  output  4  ALU op code (registered)
alu_result  input  XLEN  ALU result, combinational from alu_a/alu_b/alu_control
alu_z  input  1  ALU zero flag
out_valid  output  1  response valid
out_ready  input  1  consumer ready
out_result  output  XLEN  captured ALU result
out_rd  output  5  destination register
out_wen  output  1  register writeback enable
out_br_taken  output  1  branch taken
out_illegal  output  1  request was an illegal encoding
illegal_count  output  CNT_W  saturating count of illegal requests

Behaviour:
- Reset values:
  - e_valid = 0; out_valid = 0.
  - alu_a = 0, alu_b = 0, alu_control = 4'b0010 (ADD).
  - out_result = 0, out_rd = 0, out_wen = 0, out_br_taken = 0, out_illegal = 0, illegal_count = 0.
  - Reset mid-operation discards both stages with no output.
- ALU codes: AND 0000, OR 0001, ADD 0010, SRL 0011, XOR 0100, SLL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
- R-type decode:
  - funct3 000: ADD, or SUB if b5.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND.
  - 101: SRL, or SRA if b5.
  - b5 = 1 with funct3 outside {000, 101} is illegal.
  - alu_b = in_rs2.
- I-type decode:
  - Same map as R-type, except 000 is always ADD.
  - 001 with b5 = 1 is illegal.
  - 101 selects SRL/SRA by b5.
  - alu_b = in_imm.
- Branch decode (alu_b = in_rs2):
  - 000 BEQ: SUB, taken = z.
  - 001 BNE: SUB, taken = !z.
  - 100 BLT: SLT, taken = !z.
  - 101 BGE: SLT, taken = z.
  - 110 BLTU: SLTU, taken = !z.
  - 111 BGEU: SLTU, taken = z.
  - 010/011 are illegal.
- in_op 11 is illegal.
- Illegal request: alu_control = ADD, flows through the pipeline normally; out_illegal = 1, out_wen = 0, out_br_taken = 0.
- alu_a = in_rs1 for all ops.
- out_wen = 1 only for legal R/I-type with rd != 0. Branches: out_wen = 0. Non-branches: out_br_taken = 0.
- Pipeline control:
  - advance_w = !out_valid || out_ready.
  - advance_e = e_valid && advance_w.
  - in_ready = !e_valid || advance_w (combinational, no dependence on in_valid).
- Stage E: on accept, load alu_a, alu_b, alu_control and metadata (rd, op, funct3, illegal); set e_valid.
- Stage W: on advance_e, load out_result = alu_result and out_br_taken from alu_z and the stored funct3, plus the metadata; set out_valid.
- Valid-bit updates:
  - out_valid clears when out_valid && out_ready && !advance_e.
  - e_valid clears when advance_e && !accept.
- Latency: request accepted at edge k is presented on out_* from edge k+1. Throughput is 1 per cycle with out_ready held high.
- Stall: with out_valid && !out_ready, all out_* are stable, stage E holds (alu_* stable), and in_ready = !e_valid.
- Simultaneous accept and advance_e in one cycle: both stages load; no bubble.
- Idle: alu_* hold their last values; no change while e_valid = 0 and no accept.
- illegal_count increments by 1 when an illegal entry loads into W; it saturates at 2^CNT_W - 1 with no wrap.

Test Plan:
1. Reset, then R-type 000/b5=1, rs1=10, rs2=3, rd=5, out_ready=1 -> alu_control=0110 one cycle after accept; next cycle out_result=7, out_wen=1, out_rd=5, out_valid pulses 1 cycle.
2. I-type 101/b5=1, rs1=0x8000000000000000, imm=4 -> alu_control=0111; out_result=0xF800000000000000. Repeat with rd=0 -> out_wen=0.
3. Branch BLT 100, rs1=-1, rs2=1 -> SLT, z=0, out_br_taken=1, out_wen=0. BGEU 111, rs1=-1, rs2=1 -> SLTU result 0, out_br_taken=1.
4. Backpressure: 3 back-to-back requests with out_ready=0 -> first held on out_*, second held in E, in_ready=0. Release out_ready -> results emitted in order, 1 per cycle, none lost or duplicated.
5. Illegal: in_op=11, then R-type 010/b5=1, then branch 010 -> each gives out_illegal=1, out_wen=0, out_br_taken=0; illegal_count=3. With CNT_W=2 and 5 illegal requests -> illegal_count stays at 3.
6. Assert rst while both stages valid -> next cycle out_valid=0, in_ready=1, alu_control=0010, illegal_count=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Issue-side driver for a 64-bit combinational ALU. Decodes
//            R-type / I-type / branch requests into a 4-bit ALU code,
//            registers operands onto the ALU (stage E), captures the result
//            and branch outcome into a backpressured output stage (stage W).
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [4:0]       in_rd,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_control,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic             out_br_taken,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [3:0] c_AND  = 4'b0000;
    localparam logic [3:0] c_OR   = 4'b0001;
    localparam logic [3:0] c_ADD  = 4'b0010;
    localparam logic [3:0] c_SRL  = 4'b0011;
    localparam logic [3:0] c_XOR  = 4'b0100;
    localparam logic [3:0] c_SLL  = 4'b0101;
    localparam logic [3:0] c_SUB  = 4'b0110;
    localparam logic [3:0] c_SRA  = 4'b0111;
    localparam logic [3:0] c_SLT  = 4'b1000;
    localparam logic [3:0] c_SLTU = 4'b1001;

    localparam logic [1:0] c_OP_R  = 2'b00;
    localparam logic [1:0] c_OP_I  = 2'b01;
    localparam logic [1:0] c_OP_BR = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage E state
    logic            r_e_valid;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_ctrl;
    logic [4:0]      r_e_rd;
    logic [1:0]      r_e_op;
    logic [2:0]      r_e_f3;
    logic            r_e_ill;

    // Stage W state
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_result;
    logic [4:0]       r_out_rd;
    logic             r_out_wen;
    logic             r_out_br;
    logic             r_out_ill;
    logic [CNT_W-1:0] r_ill_cnt;

    logic            w_adv_w;
    logic            w_adv_e;
    logic            w_accept;
    logic [3:0]      w_ctrl;
    logic            w_ill;
    logic            w_br_taken;
    logic            w_wen;

    assign w_adv_w  = !r_out_valid || out_ready;
    assign w_adv_e  = r_e_valid && w_adv_w;
    assign in_ready = !r_e_valid || w_adv_w;
    assign w_accept = in_valid && in_ready;

    // Decode op/funct3/funct7b5 into the ALU code and the illegal flag
    always_comb begin
        w_ctrl = c_ADD;
        w_ill  = 1'b0;
        case (in_op)
            c_OP_R, c_OP_I: begin
                case (in_funct3)
                    3'b000: w_ctrl = (in_op == c_OP_R && in_funct7b5) ? c_SUB : c_ADD;
                    3'b001: w_ctrl = c_SLL;
                    3'b010: w_ctrl = c_SLT;
                    3'b011: w_ctrl = c_SLTU;
                    3'b100: w_ctrl = c_XOR;
                    3'b101: w_ctrl = in_funct7b5 ? c_SRA : c_SRL;
                    3'b110: w_ctrl = c_OR;
                    default: w_ctrl = c_AND;
                endcase
                // For I-type, bit 30 is immediate data except on shifts
                if (in_op == c_OP_R)
                    w_ill = in_funct7b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
                else
                    w_ill = in_funct7b5 && (in_funct3 == 3'b001);
            end
            c_OP_BR: begin
                case (in_funct3)
                    3'b000, 3'b001: w_ctrl = c_SUB;
                    3'b100, 3'b101: w_ctrl = c_SLT;
                    3'b110, 3'b111: w_ctrl = c_SLTU;
                    default:        w_ill  = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill)
            w_ctrl = c_ADD;
    end

    // Branch outcome from the zero flag; BNE/BLT/BLTU take on a non-zero result
    always_comb begin
        w_br_taken = 1'b0;
        if (r_e_op == c_OP_BR && !r_e_ill) begin
            if (r_e_f3 == 3'b001 || r_e_f3 == 3'b100 || r_e_f3 == 3'b110)
                w_br_taken = !alu_z;
            else
                w_br_taken = alu_z;
        end
    end

    assign w_wen = !r_e_ill && (r_e_op != c_OP_BR) && (r_e_rd != 5'd0);

    // Stage E: load operands, ALU code and metadata on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_valid  <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= c_ADD;
            r_e_rd     <= '0;
            r_e_op     <= '0;
            r_e_f3     <= '0;
            r_e_ill    <= 1'b0;
        end else if (w_accept) begin
            r_e_valid  <= 1'b1;
            r_alu_a    <= in_rs1;
            r_alu_b    <= (in_op == c_OP_I) ? in_imm : in_rs2;
            r_alu_ctrl <= w_ctrl;
            r_e_rd     <= in_rd;
            r_e_op     <= in_op;
            r_e_f3     <= in_funct3;
            r_e_ill    <= w_ill;
        end else if (w_adv_e) begin
            r_e_valid  <= 1'b0;
        end
    end

    // Stage W: capture ALU result and metadata when E advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_rd     <= '0;
            r_out_wen    <= 1'b0;
            r_out_br     <= 1'b0;
            r_out_ill    <= 1'b0;
        end else if (w_adv_e) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_rd     <= r_e_rd;
            r_out_wen    <= w_wen;
            r_out_br     <= w_br_taken;
            r_out_ill    <= r_e_ill;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Saturating count of illegal entries reaching stage W
    always_ff @(posedge clk) begin
        if (rst)
            r_ill_cnt <= '0;
        else if (w_adv_e && r_e_ill && r_ill_cnt != c_CNT_MAX)
            r_ill_cnt <= r_ill_cnt + c_CNT_ONE;
    end

    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_control   = r_alu_ctrl;
    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_rd        = r_out_rd;
    assign out_wen       = r_out_wen;
    assign out_br_taken  = r_out_br;
    assign out_illegal   = r_out_ill;
    assign illegal_count = r_ill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Directed self-checking bench for alu_issue_ctrl. A behavioural
//            ALU closes the loop; a second instance with CNT_W=2 shares the
//            stimulus to exercise counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_op = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic [63:0] in_rs1 = '0;
    logic [63:0] in_rs2 = '0;
    logic [63:0] in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_wen, out_br_taken, out_illegal, alu_z;
    logic [63:0] alu_a, alu_b, alu_result, out_result;
    logic [3:0]  alu_control;
    logic [4:0]  out_rd;
    logic [15:0] illegal_count;

    logic        in_ready2, out_valid2, out_wen2, out_br2, out_ill2, alu_z2;
    logic [63:0] alu_a2, alu_b2, alu_result2, out_result2;
    logic [3:0]  alu_control2;
    logic [4:0]  out_rd2;
    logic [1:0]  illegal_count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural 64-bit ALU
    function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] c);
        logic signed [63:0] sa;
        sa = a;
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a >> b[5:0];
            4'b0100: return a ^ b;
            4'b0101: return a << b[5:0];
            4'b0110: return a - b;
            4'b0111: return sa >>> b[5:0];
            4'b1000: return {63'd0, ($signed(a) < $signed(b))};
            4'b1001: return {63'd0, (a < b)};
            default: return 64'd0;
        endcase
    endfunction

    assign alu_result  = alu_f(alu_a, alu_b, alu_control);
    assign alu_z       = (alu_result == 64'd0);
    assign alu_result2 = alu_f(alu_a2, alu_b2, alu_control2);
    assign alu_z2      = (alu_result2 == 64'd0);

    alu_issue_ctrl #(.XLEN(64), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_z(alu_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wen(out_wen), .out_br_taken(out_br_taken),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    alu_issue_ctrl #(.XLEN(64), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_control(alu_control2),
        .alu_result(alu_result2), .alu_z(alu_z2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_rd(out_rd2), .out_wen(out_wen2), .out_br_taken(out_br2),
        .out_illegal(out_ill2), .illegal_count(illegal_count2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                         input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] imm, input logic [4:0] rd);
        in_valid    = 1'b1;
        in_op       = op;
        in_funct3   = f3;
        in_funct7b5 = b5;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_rd       = rd;
    endtask

    // One request through an unstalled pipeline, checking E then W
    task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic b5, input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] imm, input logic [4:0] rd,
                         input logic [3:0] e_ctrl, input logic [63:0] e_res,
                         input logic e_wen, input logic e_br, input logic e_ill);
        drive(op, f3, b5, rs1, rs2, imm, rd);
        check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check({tag, ".ctrl"}, {60'd0, alu_control}, {60'd0, e_ctrl});
        check({tag, ".alu_a"}, alu_a, rs1);
        check({tag, ".vld_e"}, {63'd0, out_valid}, 64'd0);
        tick();
        check({tag, ".vld"}, {63'd0, out_valid}, 64'd1);
        check({tag, ".res"}, out_result, e_res);
        check({tag, ".rd"}, {59'd0, out_rd}, {59'd0, rd});
        check({tag, ".wen"}, {63'd0, out_wen}, {63'd0, e_wen});
        check({tag, ".br"}, {63'd0, out_br_taken}, {63'd0, e_br});
        check({tag, ".ill"}, {63'd0, out_illegal}, {63'd0, e_ill});
        tick();
        check({tag, ".vld_off"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst.in_ready", {63'd0, in_ready}, 64'd1);
        check("rst.ctrl", {60'd0, alu_control}, 64'd2);
        check("rst.alu_a", alu_a, 64'd0);
        check("rst.alu_b", alu_b, 64'd0);
        check("rst.out_result", out_result, 64'd0);
        check("rst.out_wen", {63'd0, out_wen}, 64'd0);
        check("rst.cnt", {48'd0, illegal_count}, 64'd0);

        // R-type / I-type arithmetic
        issue("sub", 2'b00, 3'b000, 1'b1, 64'd10, 64'd3, 64'd99, 5'd5, 4'b0110, 64'd7, 1, 0, 0);
        issue("sra", 2'b01, 3'b101, 1'b1, 64'h8000000000000000, 64'd99, 64'd4, 5'd3,
              4'b0111, 64'hF800000000000000, 1, 0, 0);
        issue("sra_rd0", 2'b01, 3'b101, 1'b1, 64'h8000000000000000, 64'd99, 64'd4, 5'd0,
              4'b0111, 64'hF800000000000000, 0, 0, 0);
        issue("addi_b5", 2'b01, 3'b000, 1'b1, 64'd5, 64'd99, 64'hFFFFFFFFFFFFFFFE, 5'd9,
              4'b0010, 64'd3, 1, 0, 0);
        issue("srl", 2'b00, 3'b101, 1'b0, 64'hF0, 64'd4, 64'd0, 5'd2, 4'b0011, 64'hF, 1, 0, 0);

        // Branches
        issue("blt", 2'b10, 3'b100, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 5'd7,
              4'b1000, 64'd1, 0, 1, 0);
        issue("bgeu", 2'b10, 3'b111, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 5'd7,
              4'b1001, 64'd0, 0, 1, 0);
        issue("beq", 2'b10, 3'b000, 1'b0, 64'd5, 64'd5, 64'd0, 5'd1, 4'b0110, 64'd0, 0, 1, 0);
        issue("bne", 2'b10, 3'b001, 1'b0, 64'd5, 64'd5, 64'd0, 5'd1, 4'b0110, 64'd0, 0, 0, 0);

        // Backpressure: A to W, B in E, C refused
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 64'd1, 64'd2, 64'd0, 5'd11);
        tick();
        drive(2'b00, 3'b000, 1'b0, 64'd10, 64'd20, 64'd0, 5'd12);
        tick();
        check("bp.A_vld", {63'd0, out_valid}, 64'd1);
        check("bp.A_res", out_result, 64'd3);
        drive(2'b00, 3'b000, 1'b0, 64'd100, 64'd200, 64'd0, 5'd13);
        #1;
        check("bp.in_ready_lo", {63'd0, in_ready}, 64'd0);
        tick();
        tick();
        check("bp.A_hold", out_result, 64'd3);
        check("bp.A_rd_hold", {59'd0, out_rd}, 64'd11);
        check("bp.B_in_E", alu_a, 64'd10);
        check("bp.in_ready_hold", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_rel", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp.B_res", out_result, 64'd30);
        check("bp.B_rd", {59'd0, out_rd}, 64'd12);
        tick();
        check("bp.C_vld", {63'd0, out_valid}, 64'd1);
        check("bp.C_res", out_result, 64'd300);
        check("bp.C_rd", {59'd0, out_rd}, 64'd13);
        tick();
        check("bp.drain", {63'd0, out_valid}, 64'd0);

        // Illegal encodings and saturation
        issue("ill_op11", 2'b11, 3'b000, 1'b0, 64'd1, 64'd2, 64'd0, 5'd4, 4'b0010, 64'd3, 0, 0, 1);
        issue("ill_r010", 2'b00, 3'b010, 1'b1, 64'd4, 64'd5, 64'd0, 5'd4, 4'b0010, 64'd9, 0, 0, 1);
        issue("ill_br010", 2'b10, 3'b010, 1'b0, 64'd7, 64'd7, 64'd0, 5'd4, 4'b0010, 64'd14, 0, 0, 1);
        check("ill.cnt3", {48'd0, illegal_count}, 64'd3);
        check("ill.sat_cnt3", {62'd0, illegal_count2}, 64'd3);
        issue("ill_slli", 2'b01, 3'b001, 1'b1, 64'd1, 64'd0, 64'd1, 5'd4, 4'b0010, 64'd2, 0, 0, 1);
        issue("ill_op11b", 2'b11, 3'b111, 1'b1, 64'd0, 64'd0, 64'd0, 5'd4, 4'b0010, 64'd0, 0, 0, 1);
        check("ill.cnt5", {48'd0, illegal_count}, 64'd5);
        check("ill.sat_hold", {62'd0, illegal_count2}, 64'd3);

        // Reset with both stages valid
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 64'd1, 64'd1, 64'd0, 5'd1);
        tick();
        drive(2'b00, 3'b100, 1'b0, 64'd3, 64'd1, 64'd0, 5'd2);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check("rst2.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst2.in_ready", {63'd0, in_ready}, 64'd1);
        check("rst2.ctrl", {60'd0, alu_control}, 64'd2);
        check("rst2.cnt", {48'd0, illegal_count}, 64'd0);
        tick();
        tick();
        check("rst2.no_output", {63'd0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
